operator_emulator: RTL and testbench
====================================

Name: operator_emulator

Overview:
- Scripted stimulus source that plays the operator role for the LED sequence controller on the board.
- Watches the controller's LED pattern and drives active-low switch presses, so the controller runs its full cycle unattended.
- Used as a demo mode and as a self-test mode.
- Its outputs are muxed in front of the debouncer in place of the physical switches. Press hold times are long enough to pass debouncing.

Parameters:
- PRESS_DELAY, 100, ticks from an LED match to the start of the press.
- HOLD, 50, ticks a switch mask is held low; must exceed the debounce window.
- GAP, 20, ticks with all switches released after a press, before the next step.
- TIMEOUT, 10000, maximum ticks spent waiting for the expected LED pattern.
- LOOP, 1, 1 = restart the script after the final step; 0 = stop after one pass.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- tick  in  1  1 ms enable pulse from the time base, one CLK wide.
- enable  in  1  run the script while high.
- LED_IN  in  4  LED pattern from the controller.
- SWITCH_OUT  out  4  emulated switches, active-low; 4'b1111 = none pressed.
- step  out  3  current script step index.
- busy  out  1  high whenever the FSM is not IDLE and not HALT.
- done  out  1  one-CLK pulse at the end of each full script pass.
- error  out  1  sticky; set on a wait timeout.

Behaviour:
- Clock and reset: one clock, CLK. nRST is asynchronous and active-low. Reset values: SWITCH_OUT=4'b1111, step=0, busy=0, done=0, error=0, FSM=IDLE, counter=0.
- Script table (step: expected LED_IN -> pressed mask on SWITCH_OUT):
  - 0: 4'b0000 -> 4'b0111 (SW3, start)
  - 1: 4'b0011 -> 4'b1001 (SW1+SW2 together)
  - 2: 4'b1011 -> 4'b1110 (SW0)
  - 3: 4'b1011 -> 4'b0111 (SW3)
  - 4: 4'b0000 -> 4'b1110 (SW0, back to start)
- Tick counting: 16-bit counter, cleared on every state entry, incremented only on CLK edges where tick=1.
- FSM states: IDLE, WAIT_MATCH, DELAY, PRESS, GAP, HALT.
  - IDLE: on enable=1, go to WAIT_MATCH with step=0.
  - WAIT_MATCH: on a tick where LED_IN equals the expected pattern, go to DELAY. If the counter reaches TIMEOUT first, set error and go to HALT. Step 3 has the same expected pattern as step 2 and therefore matches immediately.
  - DELAY: when the counter reaches PRESS_DELAY, go to PRESS and drive the step mask on SWITCH_OUT from the next CLK.
  - PRESS: hold the mask for exactly HOLD ticks, then SWITCH_OUT=4'b1111 and go to GAP.
  - GAP: after GAP ticks, advance the step.
    - If step was 4: pulse done for one CLK and reset step to 0.
    - Then go to WAIT_MATCH if LOOP=1, else go to IDLE and require enable to fall and rise again.
  - HALT: SWITCH_OUT=4'b1111. Leave only when enable=0, going to IDLE.
- Clearing error: error clears on a 0->1 transition of enable, or on reset.
- Enable falling mid-operation (any state): next CLK goes to IDLE, SWITCH_OUT=4'b1111, step=0. No partial press survives.
- Parameter boundaries:
  - PRESS_DELAY=0 or GAP=0: the state lasts one CLK.
  - HOLD=0 is illegal; treat it as 1.
- Simultaneous events: tick together with a state transition counts for the new state only.
- Output timing: SWITCH_OUT, step, busy and done are registered outputs. No combinational path from LED_IN to SWITCH_OUT.
- LED_IN handling: LED_IN is treated as asynchronous and passed through a 2-flop synchronizer before comparison.

Test Plan:
- Reset, then release with enable=0 -> SWITCH_OUT=4'b1111, step=0, busy=0 for 100 ticks.
- PRESS_DELAY=2, HOLD=3, GAP=2; enable=1, LED_IN=4'b0000 -> SWITCH_OUT=4'b0111 starts 2 ticks after the match, lasts exactly 3 ticks, then step=1.
- Model the controller responding to each press -> masks appear in order 0111, 1001, 1110, 0111, 1110; one done pulse per pass; with LOOP=1, step wraps 4->0.
- TIMEOUT=20, LED_IN held at 4'b0101 -> error=1 at tick 20, SWITCH_OUT=1111, FSM in HALT; enable 0->1 clears error and restarts at step 0.
- Drop enable during PRESS of step 1 -> SWITCH_OUT=1111 on the next CLK, step=0, busy=0.
- Assert nRST low mid-PRESS, asynchronously between CLK edges -> SWITCH_OUT=1111 immediately, all outputs at reset values.

Source files
------------

// File: rtl/operator_emulator.sv
// Scripted operator for the LED sequence controller: watches the LED pattern and
// drives active-low switch presses so the controller cycles unattended.
module operator_emulator #(
    parameter int unsigned PRESS_DELAY = 100,
    parameter int unsigned HOLD        = 50,
    parameter int unsigned GAP         = 20,
    parameter int unsigned TIMEOUT     = 10000,
    parameter bit          LOOP        = 1'b1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       tick,
    input  logic       enable,
    input  logic [3:0] LED_IN,
    output logic [3:0] SWITCH_OUT,
    output logic [2:0] step,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // state      | meaning
    // S_IDLE     | waiting for enable (and re-arm after a single pass)
    // S_WAIT     | waiting for the step's expected LED pattern, bounded by TIMEOUT
    // S_DELAY    | pause between LED match and press
    // S_PRESS    | step mask driven on SWITCH_OUT
    // S_GAP      | all switches released before the next step
    // S_HALT     | timed out; parked until enable drops
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DELAY, S_PRESS, S_GAP, S_HALT
    } state_t;

    localparam int unsigned HOLD_EFF   = (HOLD == 0) ? 1 : HOLD;
    localparam logic [16:0] DELAY_TC   = 17'(PRESS_DELAY);
    localparam logic [16:0] HOLD_TC    = 17'(HOLD_EFF);
    localparam logic [16:0] GAP_TC     = 17'(GAP);
    localparam logic [16:0] TIMEOUT_TC = 17'(TIMEOUT);
    localparam logic [3:0]  SW_NONE    = 4'b1111;

    state_t      state;
    logic [15:0] cnt;
    logic [16:0] cnt_nxt;
    logic [3:0]  led_meta;
    logic [3:0]  led_sync;
    logic        enable_q;
    logic        armed;
    logic [3:0]  exp_led;
    logic [3:0]  step_mask;

    // Terminal-count compares use the count including this edge's tick, so a
    // zero-length phase lasts exactly one CLK.
    assign cnt_nxt = {1'b0, cnt} + {16'd0, tick};

    always_comb begin
        exp_led   = 4'b0000;
        step_mask = 4'b1110;
        case (step)
            3'd0: begin exp_led = 4'b0000; step_mask = 4'b0111; end
            3'd1: begin exp_led = 4'b0011; step_mask = 4'b1001; end
            3'd2: begin exp_led = 4'b1011; step_mask = 4'b1110; end
            3'd3: begin exp_led = 4'b1011; step_mask = 4'b0111; end
            default: begin exp_led = 4'b0000; step_mask = 4'b1110; end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= S_IDLE;
            cnt        <= 16'd0;
            led_meta   <= 4'b0000;
            led_sync   <= 4'b0000;
            enable_q   <= 1'b0;
            armed      <= 1'b1;
            SWITCH_OUT <= SW_NONE;
            step       <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            led_meta <= LED_IN;
            led_sync <= led_meta;
            enable_q <= enable;
            done     <= 1'b0;
            if (enable && !enable_q) begin
                error <= 1'b0;
            end

            if (!enable) begin
                state      <= S_IDLE;
                cnt        <= 16'd0;
                armed      <= 1'b1;
                SWITCH_OUT <= SW_NONE;
                step       <= 3'd0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        cnt <= 16'd0;
                        if (armed) begin
                            state <= S_WAIT;
                            step  <= 3'd0;
                            busy  <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (tick && led_sync == exp_led) begin
                            state <= S_DELAY;
                            cnt   <= 16'd0;
                        end else if (cnt_nxt >= TIMEOUT_TC) begin
                            state      <= S_HALT;
                            cnt        <= 16'd0;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            SWITCH_OUT <= SW_NONE;
                        end else begin
                            cnt <= cnt_nxt[15:0];
                        end
                    end
                    S_DELAY: begin
                        if (cnt_nxt >= DELAY_TC) begin
                            state      <= S_PRESS;
                            cnt        <= 16'd0;
                            SWITCH_OUT <= step_mask;
                        end else begin
                            cnt <= cnt_nxt[15:0];
                        end
                    end
                    S_PRESS: begin
                        if (cnt_nxt >= HOLD_TC) begin
                            state      <= S_GAP;
                            cnt        <= 16'd0;
                            SWITCH_OUT <= SW_NONE;
                        end else begin
                            cnt <= cnt_nxt[15:0];
                        end
                    end
                    S_GAP: begin
                        if (cnt_nxt >= GAP_TC) begin
                            cnt <= 16'd0;
                            if (step == 3'd4) begin
                                done <= 1'b1;
                                step <= 3'd0;
                                if (LOOP) begin
                                    state <= S_WAIT;
                                end else begin
                                    // single pass: stay idle until enable is cycled
                                    state <= S_IDLE;
                                    busy  <= 1'b0;
                                    armed <= 1'b0;
                                end
                            end else begin
                                step  <= step + 3'd1;
                                state <= S_WAIT;
                            end
                        end else begin
                            cnt <= cnt_nxt[15:0];
                        end
                    end
                    S_HALT: begin
                        cnt        <= 16'd0;
                        SWITCH_OUT <= SW_NONE;
                        busy       <= 1'b0;
                    end
                    default: begin
                        state      <= S_IDLE;
                        cnt        <= 16'd0;
                        SWITCH_OUT <= SW_NONE;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operator_emulator.sv
// Directed bench for operator_emulator: scripted controller model, timeout,
// enable drop and asynchronous reset checks.
module tb_operator_emulator;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] LED_IN = 4'b0000;
    logic [3:0] SWITCH_OUT;
    logic [2:0] step;
    logic       busy;
    logic       done;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;
    int done_cnt = 0;

    localparam logic [3:0] SW_NONE = 4'b1111;

    typedef struct {
        logic [3:0] led_after;
        logic [3:0] mask;
        logic [2:0] stp;
        logic [2:0] stp_next;
    } vec_t;

    vec_t vecs [5];

    operator_emulator #(
        .PRESS_DELAY(2),
        .HOLD(3),
        .GAP(2),
        .TIMEOUT(20),
        .LOOP(1'b1)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .tick(tick),
        .enable(enable),
        .LED_IN(LED_IN),
        .SWITCH_OUT(SWITCH_OUT),
        .step(step),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 CLK = ~CLK;

    initial begin
        forever begin
            repeat (3) @(posedge CLK);
            #1 tick = 1'b1;
            @(posedge CLK);
            #1 tick = 1'b0;
        end
    end

    always @(posedge CLK) begin
        if (tick) tick_cnt <= tick_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_sw_change(input logic [3:0] from, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            if (SWITCH_OUT !== from) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_step_change(input logic [2:0] from, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            if (step !== from) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic align_to_tick();
        int prev;
        prev = tick_cnt;
        do @(negedge CLK); while (tick_cnt == prev);
    endtask

    initial begin
        bit ok;
        int e;
        int t0;
        int bad;
        int start;

        vecs[0] = '{led_after: 4'b0011, mask: 4'b0111, stp: 3'd0, stp_next: 3'd1};
        vecs[1] = '{led_after: 4'b1011, mask: 4'b1001, stp: 3'd1, stp_next: 3'd2};
        vecs[2] = '{led_after: 4'b1011, mask: 4'b1110, stp: 3'd2, stp_next: 3'd3};
        vecs[3] = '{led_after: 4'b0000, mask: 4'b0111, stp: 3'd3, stp_next: 3'd4};
        vecs[4] = '{led_after: 4'b0000, mask: 4'b1110, stp: 3'd4, stp_next: 3'd0};

        // reset values
        repeat (3) @(negedge CLK);
        check("rst_switch", 32'(SWITCH_OUT), 32'(SW_NONE));
        check("rst_step", 32'(step), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        nRST = 1'b1;

        // disabled: quiet for 100 ticks
        bad = 0;
        start = tick_cnt;
        while (tick_cnt < start + 100) begin
            @(negedge CLK);
            if (SWITCH_OUT !== SW_NONE || busy !== 1'b0 || step !== 3'd0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // full script, two passes, controller model answering each press
        align_to_tick();
        enable = 1'b1;
        e = tick_cnt;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 5; i++) begin
                wait_sw_change(SW_NONE, ok);
                check("press_seen", 32'(ok), 32'd1);
                t0 = tick_cnt;
                check("press_mask", 32'(SWITCH_OUT), 32'(vecs[i].mask));
                check("press_step", 32'(step), 32'(vecs[i].stp));
                check("press_busy", 32'(busy), 32'd1);
                if (pass == 0 && i == 0) check("press_delay_ticks", 32'(t0 - e), 32'd3);
                wait_sw_change(vecs[i].mask, ok);
                check("release_seen", 32'(ok), 32'd1);
                check("release_val", 32'(SWITCH_OUT), 32'(SW_NONE));
                check("hold_ticks", 32'(tick_cnt - t0), 32'd3);
                LED_IN = vecs[i].led_after;
                wait_step_change(vecs[i].stp, ok);
                check("step_adv_seen", 32'(ok), 32'd1);
                check("step_next", 32'(step), 32'(vecs[i].stp_next));
                if (i == 4) begin
                    repeat (2) @(negedge CLK);
                    check("done_count", 32'(done_cnt), 32'(pass + 1));
                    check("loop_busy", 32'(busy), 32'd1);
                end
            end
        end

        // drop enable during the step 1 press
        wait_sw_change(SW_NONE, ok);
        check("s0_mask", 32'(SWITCH_OUT), 32'b0111);
        wait_sw_change(4'b0111, ok);
        LED_IN = 4'b0011;
        wait_sw_change(SW_NONE, ok);
        check("s1_mask", 32'(SWITCH_OUT), 32'b1001);
        enable = 1'b0;
        @(negedge CLK);
        check("drop_switch", 32'(SWITCH_OUT), 32'(SW_NONE));
        check("drop_step", 32'(step), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);

        // timeout with a pattern that never matches
        repeat (5) @(negedge CLK);
        LED_IN = 4'b0101;
        repeat (3) @(negedge CLK);
        align_to_tick();
        enable = 1'b1;
        e = tick_cnt;
        while (tick_cnt < e + 19) @(negedge CLK);
        check("to_error_before", 32'(error), 32'd0);
        check("to_busy_before", 32'(busy), 32'd1);
        while (tick_cnt < e + 20) @(negedge CLK);
        check("to_error", 32'(error), 32'd1);
        check("to_switch", 32'(SWITCH_OUT), 32'(SW_NONE));
        check("to_busy_halt", 32'(busy), 32'd0);
        repeat (20) @(negedge CLK);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_error", 32'(error), 32'd1);
        enable = 1'b0;
        repeat (2) @(negedge CLK);
        check("error_sticky", 32'(error), 32'd1);
        LED_IN = 4'b0000;
        @(negedge CLK);
        enable = 1'b1;
        @(negedge CLK);
        check("error_cleared", 32'(error), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_step", 32'(step), 32'd0);
        wait_sw_change(SW_NONE, ok);
        check("restart_mask", 32'(SWITCH_OUT), 32'b0111);

        // asynchronous reset during the step 1 press
        wait_sw_change(4'b0111, ok);
        LED_IN = 4'b0011;
        wait_sw_change(SW_NONE, ok);
        check("pre_rst_mask", 32'(SWITCH_OUT), 32'b1001);
        #2 nRST = 1'b0;
        #1;
        check("arst_switch", 32'(SWITCH_OUT), 32'(SW_NONE));
        check("arst_step", 32'(step), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
